// File: rtl/barrel_unshifter_seq.sv
// barrel_unshifter_seq: undoes a barrel shift/rotate one bit position per clock.
// Handshake: start accepted in IDLE, busy while working, one-cycle done pulse.
module barrel_unshifter_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             barrel_unshifter_seq_clk,
  input  logic             barrel_unshifter_seq_rst,
  input  logic             barrel_unshifter_seq_start,
  input  logic [WIDTH-1:0] barrel_unshifter_seq_data_in,
  input  logic [SHW-1:0]   barrel_unshifter_seq_shift,
  input  logic             barrel_unshifter_seq_sr,
  input  logic             barrel_unshifter_seq_direction,
  output logic [WIDTH-1:0] barrel_unshifter_seq_data_out,
  output logic             barrel_unshifter_seq_busy,
  output logic             barrel_unshifter_seq_done,
  output logic             barrel_unshifter_seq_lossy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] workReg;
  logic [SHW-1:0]   stepCount;
  logic             srLatched;
  logic             dirLatched;
  logic [WIDTH-1:0] steppedWord;

  // One-bit step opposite to the original direction; rotate or zero fill.
  always_comb begin
    steppedWord = workReg;
    if (!dirLatched) begin
      steppedWord = {(srLatched ? workReg[0] : 1'b0), workReg[WIDTH-1:1]};
    end else begin
      steppedWord = {workReg[WIDTH-2:0], (srLatched ? workReg[WIDTH-1] : 1'b0)};
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge barrel_unshifter_seq_clk or negedge barrel_unshifter_seq_rst) begin
    if (!barrel_unshifter_seq_rst) begin
      state                         <= IDLE;
      workReg                       <= '0;
      stepCount                     <= '0;
      srLatched                     <= 1'b0;
      dirLatched                    <= 1'b0;
      barrel_unshifter_seq_data_out <= '0;
      barrel_unshifter_seq_busy     <= 1'b0;
      barrel_unshifter_seq_done     <= 1'b0;
      barrel_unshifter_seq_lossy    <= 1'b0;
    end else begin
      barrel_unshifter_seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (barrel_unshifter_seq_start) begin
            workReg                    <= barrel_unshifter_seq_data_in;
            stepCount                  <= barrel_unshifter_seq_shift;
            srLatched                  <= barrel_unshifter_seq_sr;
            dirLatched                 <= barrel_unshifter_seq_direction;
            barrel_unshifter_seq_lossy <= ~barrel_unshifter_seq_sr &
                                          (barrel_unshifter_seq_shift != '0);
            barrel_unshifter_seq_busy  <= 1'b1;
            if (barrel_unshifter_seq_shift == '0) begin
              barrel_unshifter_seq_data_out <= barrel_unshifter_seq_data_in;
              barrel_unshifter_seq_done     <= 1'b1;
              state                         <= DONE;
            end else begin
              state <= STEP;
            end
          end
        end
        STEP: begin
          workReg   <= steppedWord;
          stepCount <= stepCount - SHW'(1);
          if (stepCount == SHW'(1)) begin
            barrel_unshifter_seq_data_out <= steppedWord;
            barrel_unshifter_seq_done     <= 1'b1;
            state                         <= DONE;
          end
        end
        DONE: begin
          barrel_unshifter_seq_busy <= 1'b0;
          state                     <= IDLE;
        end
        default: begin
          barrel_unshifter_seq_busy <= 1'b0;
          state                     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_unshifter_seq.sv
// Scoreboard bench for barrel_unshifter_seq: directed requests push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_barrel_unshifter_seq;

  logic        clk;
  logic        rstN;
  logic        start;
  logic [31:0] dataIn;
  logic [4:0]  shiftIn;
  logic        srIn;
  logic        dirIn;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic        lossy;

  int nTests;
  int nFail;
  int doneSeen;
  int reqCount;

  typedef struct {
    logic [31:0] data;
    logic        lossy;
  } exp_t;

  exp_t sbq[$];

  barrel_unshifter_seq #(.WIDTH(32), .SHW(5)) dut (
    .barrel_unshifter_seq_clk       (clk),
    .barrel_unshifter_seq_rst       (rstN),
    .barrel_unshifter_seq_start     (start),
    .barrel_unshifter_seq_data_in   (dataIn),
    .barrel_unshifter_seq_shift     (shiftIn),
    .barrel_unshifter_seq_sr        (srIn),
    .barrel_unshifter_seq_direction (dirIn),
    .barrel_unshifter_seq_data_out  (dataOut),
    .barrel_unshifter_seq_busy      (busy),
    .barrel_unshifter_seq_done      (done),
    .barrel_unshifter_seq_lossy     (lossy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      doneSeen++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("data_out", dataOut, e.data);
        chk("lossy", 32'(lossy), 32'(e.lossy));
        chk("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  // Issue one request from a negedge and follow it to completion.
  task automatic runReq(input logic [31:0] d, input logic [4:0] s, input logic sr,
                        input logic dir, input logic [31:0] expD, input logic expL,
                        input bit injectStart, input string name);
    int idx;
    int busyCnt;
    bit gotDone;
    exp_t e;
    e.data  = expD;
    e.lossy = expL;
    sbq.push_back(e);
    reqCount++;
    start   = 1'b1;
    dataIn  = d;
    shiftIn = s;
    srIn    = sr;
    dirIn   = dir;
    @(posedge clk);
    #1;
    start   = 1'b0;
    dataIn  = 32'hFFFF_FFFF;
    shiftIn = 5'd7;
    srIn    = ~sr;
    dirIn   = ~dir;
    idx     = 0;
    busyCnt = 0;
    gotDone = 1'b0;
    while (!gotDone && idx < 100) begin
      @(negedge clk);
      if (busy === 1'b1) busyCnt++;
      if (done === 1'b1) gotDone = 1'b1;
      else idx++;
      if (injectStart) start = (idx == 2);
    end
    start = 1'b0;
    chk({name, "_done_seen"}, 32'(gotDone), 32'd1);
    chk({name, "_latency"}, 32'(idx), 32'(s));
    chk({name, "_busy_cycles"}, 32'(busyCnt), 32'(s) + 32'd1);
    @(negedge clk);
    chk({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    nTests   = 0;
    nFail    = 0;
    doneSeen = 0;
    reqCount = 0;
    rstN     = 1'b0;
    start    = 1'b0;
    dataIn   = '0;
    shiftIn  = '0;
    srIn     = 1'b0;
    dirIn    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {dataOut[29:0], busy, done} | {31'd0, lossy}, 32'd0);
    chk("reset_data_out", dataOut, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    runReq(32'h0000_001F, 5'd4,  1'b1, 1'b0, 32'hF000_0001, 1'b0, 1'b0, "rotate");
    runReq(32'h0012_3456, 5'd8,  1'b0, 1'b1, 32'h1234_5600, 1'b1, 1'b0, "logical");
    runReq(32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, "zero_shift");
    runReq(32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b0, "max_rotate");
    runReq(32'h0000_001F, 5'd4,  1'b1, 1'b0, 32'hF000_0001, 1'b0, 1'b1, "start_busy");
    runReq(32'h8000_0001, 5'd1,  1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b0, "logical_left");
    runReq(32'h1234_ABCD, 5'd16, 1'b1, 1'b1, 32'hABCD_1234, 1'b0, 1'b0, "rotate_half");
    runReq(32'h5A5A_5A5A, 5'd0,  1'b0, 1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0, "zero_logical");

    // Abort the logical request at step 3 with an asynchronous reset.
    start   = 1'b1;
    dataIn  = 32'h0012_3456;
    shiftIn = 5'd8;
    srIn    = 1'b0;
    dirIn   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    chk("abort_data_out", dataOut, 32'd0);
    chk("abort_flags", {29'd0, busy, done, lossy}, 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(doneSeen), 32'(reqCount));

    runReq(32'h0012_3456, 5'd8,  1'b0, 1'b1, 32'h1234_5600, 1'b1, 1'b0, "after_abort");

    repeat (4) @(negedge clk);
    chk("done_count", 32'(doneSeen), 32'(reqCount));
    chk("queue_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/barrel_unshifter_seq.md
Name: barrel_unshifter_seq

Overview:
Sequential inverse of the combinational barrel shifter. It takes a word that was shifted or rotated by a known amount and direction, and undoes the operation one bit position per clock. The bench places it downstream of the barrel shifter to close the loop back to the counter value. It uses a start/busy/done handshake so the design can check its round-trip results.

Parameters:
WIDTH, 32, data word width
SHW, 5, shift-amount width; must equal log2(WIDTH)

Ports:
barrel_unshifter_seq_clk  input  1  system clock, rising-edge active
barrel_unshifter_seq_rst  input  1  reset, asynchronous, active-low
barrel_unshifter_seq_start  input  1  request; sampled only in IDLE
barrel_unshifter_seq_data_in  input  WIDTH  already-shifted word
barrel_unshifter_seq_shift  input  SHW  amount of the original forward shift
barrel_unshifter_seq_sr  input  1  original mode: 1 = rotate, 0 = logical shift (zero fill)
barrel_unshifter_seq_direction  input  1  original forward direction: 0 = left, 1 = right
barrel_unshifter_seq_data_out  output  WIDTH  recovered word
barrel_unshifter_seq_busy  output  1  high whenever state is not IDLE
barrel_unshifter_seq_done  output  1  one-cycle pulse; data_out valid from this cycle on
barrel_unshifter_seq_lossy  output  1  result not exactly recoverable (sr=0 and shift!=0)

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. data_out, busy, done, lossy, the work register and the step counter all go to 0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, STEP, DONE.
- IDLE, start=1 at edge E0:
  - Latch data_in into the work register; latch shift into the counter; latch sr and direction.
  - lossy <= (~sr & (shift!=0)).
  - If shift==0: go to DONE and set data_out <= data_in.
  - Otherwise go to STEP.
- STEP, each edge:
  - Shift the work register 1 bit opposite to the latched direction (direction=0 → step right; direction=1 → step left).
  - sr=1: the bit shifted out re-enters at the other end. sr=0: the vacated bit is filled with 0.
  - Counter decrements. On the edge where the counter goes 1 → 0, data_out <= stepped value and the state goes to DONE.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: for N = latched shift, done is high in the cycle after edge E_N (E_0 = acceptance edge). Throughput is one request per N+2 cycles.
- busy = (state != IDLE); it goes high the cycle after E0.
- start is ignored in STEP and DONE; no queuing.
- Inputs other than start are ignored after E0.
- data_out holds its last result until the next DONE entry. It never shows intermediate values.
- lossy holds until the next accepted start.
- A start held continuously high re-triggers immediately on the first IDLE cycle after DONE.
- The step counter is SHW bits. Maximum N is WIDTH-1; there is no wrap.

Test Plan:
- Rotate recovery: data_in=0x0000_001F, shift=4, sr=1, direction=0 → done 4 cycles after acceptance, data_out=0xF000_0001, lossy=0.
- Logical recovery: data_in=0x0012_3456, shift=8, sr=0, direction=1 → data_out=0x1234_5600 after 8 steps, lossy=1.
- Zero shift: data_in=0xDEAD_BEEF, shift=0, sr=1 → done in the cycle after acceptance, data_out=0xDEAD_BEEF, busy high exactly 1 cycle.
- Max rotate: data_in=0x8000_0000, shift=31, sr=1, direction=1 → data_out=0x4000_0000 after 31 steps; busy high for 32 cycles.
- Start while busy: second start pulse with data_in=0xFFFF_FFFF during STEP of the rotate test → ignored; result still 0xF000_0001; exactly one done pulse.
- Reset mid-operation: rst low asynchronously at step 3 of the logical test → data_out, busy, done, lossy all 0 immediately, no done pulse; a new request after rst high completes normally.
